// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port shared between the UART loader and the memory.
// Purely combinational wiring; no latency of its own.
// No backpressure: the memory must accept every MemWrite strobe.
interface imem_uart_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [31:0]           MemWriteData;

  modport master (output MemWrite, output MemAddr, output MemWriteData);
  modport slave  (input  MemWrite, input  MemAddr, input  MemWriteData);
endinterface

// File: rtl/imem_uart_loader.sv
// UART program loader: sync byte, 16-bit word count, then MSB-first 32-bit words into imem.
// MemWrite fires 2 Clk cycles after the stop-bit sample of each word's 4th byte.
// No backpressure: memory must take every write; UART bytes cannot be throttled.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10,
  parameter int MAX_WORDS    = 1024,
  parameter int TIMEOUT_CLKS = 1 << 24
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rx,
  imem_uart_loader_if.master mem,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordCount
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int IW = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------------
  // Rx synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  wire rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t  r_state, r_next;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          stb_c, ferr_c;
  logic          byte_vld, frame_vld;
  logic [7:0]    byte_dat;

  wire half_hit = (clk_cnt == HALF_LAST);
  wire bit_hit  = (clk_cnt == BIT_LAST);

  // RX state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // RX next state: half-bit to the start centre, then full bit periods.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rx_fall) r_next = R_START;
      R_START: if (half_hit) r_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (bit_hit && bit_idx == 3'd7) r_next = R_STOP;
      R_STOP:  if (bit_hit) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RX outputs: byte strobe on a good stop bit, framing error on a low one.
  always_comb begin
    stb_c  = 1'b0;
    ferr_c = 1'b0;
    if (r_state == R_STOP && bit_hit) begin
      stb_c  = rx_sync;
      ferr_c = ~rx_sync;
    end
  end

  // RX datapath: bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        R_START: clk_cnt <= half_hit ? '0 : clk_cnt + 1'b1;
        R_DATA: begin
          if (bit_hit) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_STOP: clk_cnt <= bit_hit ? '0 : clk_cnt + 1'b1;
        default: clk_cnt <= '0;
      endcase
    end
  end

  // Register the byte strobe and framing error so the loader sees clean one-cycle pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      byte_vld  <= 1'b0;
      frame_vld <= 1'b0;
      byte_dat  <= '0;
    end else begin
      byte_vld  <= stb_c;
      frame_vld <= ferr_c;
      if (stb_c) byte_dat <= rx_shift;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} ld_state_t;
  ld_state_t   l_state, l_next;
  logic [IW-1:0] addr_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;
  logic [15:0]   word_count;
  logic [TW-1:0] to_cnt;

  wire is_sync   = byte_vld && (byte_dat == SYNC_BYTE);
  wire in_load   = (l_state == LEN_LO) || (l_state == LEN_HI) || (l_state == DATA);
  wire timeout   = in_load && (to_cnt == TO_LAST);
  wire [15:0] hdr_count = {byte_dat, word_count[7:0]};
  wire last_word = (32'(addr_idx) + 32'd1) == 32'(word_count);

  // Loader state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) l_state <= IDLE;
    else        l_state <= l_next;
  end

  // Loader next state; framing errors and timeouts abort any load in progress.
  always_comb begin
    l_next = l_state;
    case (l_state)
      IDLE, DONE, ERROR: if (is_sync) l_next = LEN_LO;
      LEN_LO: begin
        if (frame_vld || timeout) l_next = ERROR;
        else if (byte_vld)        l_next = LEN_HI;
      end
      LEN_HI: begin
        if (frame_vld || timeout) l_next = ERROR;
        else if (byte_vld) begin
          if (hdr_count == 16'd0)                     l_next = DONE;
          else if (32'(hdr_count) > 32'(MAX_WORDS))   l_next = ERROR;
          else                                        l_next = DATA;
        end
      end
      DATA: begin
        if (frame_vld || timeout)                l_next = ERROR;
        else if (byte_vld && byte_idx == 2'd3)   l_next = WRITE;
      end
      WRITE: begin
        if (frame_vld)      l_next = ERROR;
        else if (last_word) l_next = DONE;
        else                l_next = DATA;
      end
      default: l_next = IDLE;
    endcase
  end

  // Loader outputs decoded from state; ERROR keeps the CPU held.
  always_comb begin
    mem.MemWrite     = (l_state == WRITE);
    mem.MemAddr      = addr_idx[ADDR_WIDTH-1:0];
    mem.MemWriteData = word_buf;
    WordCount        = word_count;
    Done             = (l_state == DONE);
    Error            = (l_state == ERROR);
    CpuHold          = (l_state != IDLE) && (l_state != DONE);
  end

  // Loader datapath: header capture, word assembly and write index.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      word_count <= '0;
    end else begin
      case (l_state)
        IDLE, DONE, ERROR: begin
          if (is_sync) begin
            addr_idx <= '0;
            byte_idx <= '0;
          end
        end
        LEN_LO: if (byte_vld) word_count[7:0]  <= byte_dat;
        LEN_HI: if (byte_vld) word_count[15:8] <= byte_dat;
        DATA: begin
          if (byte_vld) begin
            word_buf <= {word_buf[23:0], byte_dat};
            byte_idx <= byte_idx + 1'b1;
          end
        end
        WRITE: addr_idx <= addr_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Inter-byte timeout: runs only while waiting for header/data bytes, restarts on each byte.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                 to_cnt <= '0;
    else if (!in_load || byte_vld) to_cnt <= '0;
    else if (!timeout)          to_cnt <= to_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with a write scoreboard.
module tb_imem_uart_loader;
  localparam int CPB = 16;
  localparam int AW  = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Rx = 1'b1;
  logic        CpuHold, Done, Error;
  logic [15:0] WordCount;

  int tests = 0;
  int fails = 0;
  logic [AW+31:0] exp_q[$];

  imem_uart_loader_if #(.ADDR_WIDTH(AW)) mem ();

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .MAX_WORDS(1024), .TIMEOUT_CLKS(4096)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Rx(Rx), .mem(mem.master),
    .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordCount(WordCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    Rx = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (CPB) @(negedge Clk);
    end
    Rx = stop_bit;
    repeat (CPB) @(negedge Clk);
    Rx = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_ok(w[31:24]);
    send_ok(w[23:16]);
    send_ok(w[15:8]);
    send_ok(w[7:0]);
  endtask

  // Write monitor: every MemWrite must match the oldest expected (addr, data).
  always @(negedge Clk) begin
    if (mem.MemWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem.MemAddr), 32'(e[AW+31:32]));
        chk("wr_data", mem.MemWriteData, e[31:0]);
        chk("wr_hold", 32'(CpuHold), 32'd1);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_memwrite", 32'(mem.MemWrite), 32'd0);
    chk("rst_hold", 32'(CpuHold), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_count", 32'(WordCount), 32'd0);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);

    // 1: two-word load
    exp_q.push_back({10'd0, 32'h20080005});
    exp_q.push_back({10'd1, 32'h2009000A});
    send_ok(8'hA5);
    chk("t1_hold_hdr", 32'(CpuHold), 32'd1);
    chk("t1_done_hdr", 32'(Done), 32'd0);
    send_ok(8'h02);
    send_ok(8'h00);
    send_word(32'h20080005);
    send_word(32'h2009000A);
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_hold", 32'(CpuHold), 32'd0);
    chk("t1_error", 32'(Error), 32'd0);
    chk("t1_count", 32'(WordCount), 32'd2);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: zero-length load
    send_ok(8'hA5);
    chk("t2_hold_hdr", 32'(CpuHold), 32'd1);
    chk("t2_done_hdr", 32'(Done), 32'd0);
    send_ok(8'h00);
    send_ok(8'h00);
    chk("t2_done", 32'(Done), 32'd1);
    chk("t2_hold", 32'(CpuHold), 32'd0);
    chk("t2_count", 32'(WordCount), 32'd0);

    // 3: framing error mid-word, later bytes ignored, then recovery
    send_ok(8'hA5);
    send_ok(8'h01);
    send_ok(8'h00);
    send_ok(8'h12);
    send_byte(8'h55, 1'b0);
    chk("t3_error", 32'(Error), 32'd1);
    chk("t3_hold", 32'(CpuHold), 32'd1);
    send_word(32'h11223344);
    chk("t3_error_stays", 32'(Error), 32'd1);
    exp_q.push_back({10'd0, 32'hDEADBEEF});
    send_ok(8'hA5);
    chk("t3_error_clr", 32'(Error), 32'd0);
    send_ok(8'h01);
    send_ok(8'h00);
    send_word(32'hDEADBEEF);
    chk("t3_done", 32'(Done), 32'd1);
    chk("t3_err_final", 32'(Error), 32'd0);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: count above MAX_WORDS
    send_ok(8'hA5);
    send_ok(8'h01);
    send_ok(8'h04);
    chk("t4_error", 32'(Error), 32'd1);
    chk("t4_hold", 32'(CpuHold), 32'd1);
    chk("t4_count", 32'(WordCount), 32'h0401);

    // 5: inter-byte timeout
    send_ok(8'hA5);
    send_ok(8'h01);
    send_ok(8'h00);
    send_ok(8'h12);
    send_ok(8'h34);
    repeat (3000) @(negedge Clk);
    chk("t5_no_early_to", 32'(Error), 32'd0);
    repeat (1200) @(negedge Clk);
    chk("t5_timeout", 32'(Error), 32'd1);
    chk("t5_hold", 32'(CpuHold), 32'd1);

    // 6: reset in the middle of a three-word load, then reload from address 0
    exp_q.push_back({10'd0, 32'hA1B2C3D4});
    send_ok(8'hA5);
    send_ok(8'h03);
    send_ok(8'h00);
    send_word(32'hA1B2C3D4);
    send_ok(8'h55);
    send_ok(8'h66);
    chk("t6_drain_w0", 32'(exp_q.size()), 32'd0);
    Reset = 1'b0;
    #1;
    chk("t6_rst_hold", 32'(CpuHold), 32'd0);
    chk("t6_rst_done", 32'(Done), 32'd0);
    chk("t6_rst_error", 32'(Error), 32'd0);
    chk("t6_rst_count", 32'(WordCount), 32'd0);
    chk("t6_rst_wr", 32'(mem.MemWrite), 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    exp_q.push_back({10'd0, 32'hCAFEF00D});
    send_ok(8'hA5);
    send_ok(8'h01);
    send_ok(8'h00);
    send_word(32'hCAFEF00D);
    chk("t6_done", 32'(Done), 32'd1);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);

    // Glitch: a one-cycle low pulse while in LEN_LO must not become a byte
    send_ok(8'hA5);
    Rx = 1'b0;
    @(negedge Clk);
    Rx = 1'b1;
    repeat (12 * CPB) @(negedge Clk);
    send_ok(8'h00);
    send_ok(8'h00);
    chk("glitch_done", 32'(Done), 32'd1);
    chk("glitch_count", 32'(WordCount), 32'd0);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
